// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register offsets, address width and
// the debounce agreement threshold.
package gpio_bank_pkg;

  localparam int unsigned ADDR_WIDTH      = 5;
  localparam int unsigned AGREE_THRESHOLD = 3;

  localparam logic [ADDR_WIDTH-1:0] OUT_OFFSET         = 5'h00;
  localparam logic [ADDR_WIDTH-1:0] OE_OFFSET          = 5'h04;
  localparam logic [ADDR_WIDTH-1:0] IN_OFFSET          = 5'h08;
  localparam logic [ADDR_WIDTH-1:0] DBNC_EN_OFFSET     = 5'h0C;
  localparam logic [ADDR_WIDTH-1:0] DBNC_LIMIT_OFFSET  = 5'h10;
  localparam logic [ADDR_WIDTH-1:0] IRQ_RISE_EN_OFFSET = 5'h14;
  localparam logic [ADDR_WIDTH-1:0] IRQ_FALL_EN_OFFSET = 5'h18;
  localparam logic [ADDR_WIDTH-1:0] IRQ_STATUS_OFFSET  = 5'h1C;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO pin: input synchroniser, tick-paced agreement filter and the
// filt/prev pair used by the bank's edge detector.
module gpio_debounce
  import gpio_bank_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic gp_i,
  input  logic tick_i,
  input  logic dbnc_en_i,
  output logic filt_o,
  output logic prev_o
);

  localparam logic [1:0] AgreeLast = 2'(AGREE_THRESHOLD - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_s;
  logic [1:0]            agree_q, agree_d;
  logic                  filt_q, filt_d;
  logic                  prev_q;

  assign sync_s = sync_q[SyncStages-1];

  // Filter next state; the counter only advances on ticks while input and filter disagree
  always_comb begin
    agree_d = agree_q;
    filt_d  = filt_q;
    if (!dbnc_en_i) begin
      filt_d  = sync_s;
      agree_d = 2'd0;
    end else if (sync_s == filt_q) begin
      agree_d = 2'd0;
    end else if (tick_i) begin
      if (agree_q == AgreeLast) begin
        filt_d  = ~filt_q;
        agree_d = 2'd0;
      end else begin
        agree_d = agree_q + 2'd1;
      end
    end else begin
      agree_d = agree_q;
    end
  end

  // Synchroniser chain, filter state and edge history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {SyncStages{1'b0}};
      agree_q <= 2'd0;
      filt_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], gp_i};
      agree_q <= agree_d;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
    end
  end

  assign filt_o = filt_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: register file, shared debounce tick counter and
// per-pin filters with rise/fall interrupt status.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned GpioWidth    = 16,
  parameter int unsigned DbncCntWidth = 16,
  parameter int unsigned SyncStages   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_rvalid_o,
  input  logic [GpioWidth-1:0]  gp_i,
  output logic [GpioWidth-1:0]  gp_o,
  output logic [GpioWidth-1:0]  gp_oe_o,
  output logic                  irq_o
);

  localparam logic [GpioWidth-1:0]    GpioZero = {GpioWidth{1'b0}};
  localparam logic [DbncCntWidth-1:0] CntZero  = {DbncCntWidth{1'b0}};
  localparam logic [DbncCntWidth-1:0] CntOne   = DbncCntWidth'(1);

  logic [ADDR_WIDTH-1:0]   addr_s;
  logic                    wr_s, rd_s;
  logic [GpioWidth-1:0]    wdata_s;

  logic [GpioWidth-1:0]    out_q, out_d;
  logic [GpioWidth-1:0]    oe_q, oe_d;
  logic [GpioWidth-1:0]    dbnc_en_q, dbnc_en_d;
  logic [GpioWidth-1:0]    rise_en_q, rise_en_d;
  logic [GpioWidth-1:0]    fall_en_q, fall_en_d;
  logic [GpioWidth-1:0]    status_q, status_d;
  logic [DbncCntWidth-1:0] limit_q, limit_d;
  logic [DbncCntWidth-1:0] tcnt_q, tcnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvalid_q;
  logic                    irq_q;

  logic                    tick_s;
  logic                    limit_wr_s;
  logic [GpioWidth-1:0]    w1c_s;
  logic [GpioWidth-1:0]    filt_s, prev_s, set_s;
  logic                    unused_s;

  assign addr_s     = {reg_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign wr_s       = reg_req_i & reg_we_i;
  assign rd_s       = reg_req_i & ~reg_we_i;
  assign wdata_s    = reg_wdata_i[GpioWidth-1:0];
  assign limit_wr_s = wr_s && (addr_s == DBNC_LIMIT_OFFSET);
  assign unused_s   = ^{reg_addr_i[1:0], reg_wdata_i};

  // Register writes; IRQ_STATUS writes only produce a clear mask
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    dbnc_en_d = dbnc_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    limit_d   = limit_q;
    w1c_s     = GpioZero;
    if (wr_s) begin
      case (addr_s)
        OUT_OFFSET:         out_d     = wdata_s;
        OE_OFFSET:          oe_d      = wdata_s;
        DBNC_EN_OFFSET:     dbnc_en_d = wdata_s;
        DBNC_LIMIT_OFFSET:  limit_d   = reg_wdata_i[DbncCntWidth-1:0];
        IRQ_RISE_EN_OFFSET: rise_en_d = wdata_s;
        IRQ_FALL_EN_OFFSET: fall_en_d = wdata_s;
        IRQ_STATUS_OFFSET:  w1c_s     = wdata_s;
        default:            w1c_s     = GpioZero;
      endcase
    end else begin
      w1c_s = GpioZero;
    end
  end

  // Read mux; data is forced to zero for writes and idle cycles
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      case (addr_s)
        OUT_OFFSET:         rdata_d = 32'(out_q);
        OE_OFFSET:          rdata_d = 32'(oe_q);
        IN_OFFSET:          rdata_d = 32'(filt_s);
        DBNC_EN_OFFSET:     rdata_d = 32'(dbnc_en_q);
        DBNC_LIMIT_OFFSET:  rdata_d = 32'(limit_q);
        IRQ_RISE_EN_OFFSET: rdata_d = 32'(rise_en_q);
        IRQ_FALL_EN_OFFSET: rdata_d = 32'(fall_en_q);
        IRQ_STATUS_OFFSET:  rdata_d = 32'(status_q);
        default:            rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Shared debounce tick: counts 0..limit, restarts on any limit write
  assign tick_s = (tcnt_q == limit_q);

  always_comb begin
    tcnt_d = tcnt_q;
    if (limit_wr_s) begin
      tcnt_d = CntZero;
    end else if (tick_s) begin
      tcnt_d = CntZero;
    end else begin
      tcnt_d = tcnt_q + CntOne;
    end
  end

  for (genvar g = 0; g < GpioWidth; g++) begin : g_pin
    gpio_debounce #(
      .SyncStages(SyncStages)
    ) u_dbnc (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .gp_i     (gp_i[g]),
      .tick_i   (tick_s),
      .dbnc_en_i(dbnc_en_q[g]),
      .filt_o   (filt_s[g]),
      .prev_o   (prev_s[g])
    );
  end

  // A new edge wins over a same-cycle clear of the same bit
  assign set_s    = (filt_s & ~prev_s & rise_en_q) | (~filt_s & prev_s & fall_en_q);
  assign status_d = (status_q & ~w1c_s) | set_s;

  // All architectural state of the bank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q     <= GpioZero;
      oe_q      <= GpioZero;
      dbnc_en_q <= GpioZero;
      rise_en_q <= GpioZero;
      fall_en_q <= GpioZero;
      status_q  <= GpioZero;
      limit_q   <= CntZero;
      tcnt_q    <= CntZero;
      rdata_q   <= 32'h0000_0000;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      dbnc_en_q <= dbnc_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      limit_q   <= limit_d;
      tcnt_q    <= tcnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= reg_req_i;
      irq_q     <= |status_q;
    end
  end

  assign gp_o         = out_q;
  assign gp_oe_o      = oe_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: constant vector table, directed
// multi-cycle sequences and randomised traffic against a behavioural model.
module tb_gpio_bank;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int S  = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          reg_req_i = 1'b0;
  logic          reg_we_i = 1'b0;
  logic [4:0]    reg_addr_i = 5'h00;
  logic [31:0]   reg_wdata_i = 32'h0;
  logic [31:0]   reg_rdata_o;
  logic          reg_rvalid_o;
  logic [W-1:0]  gp_i = 16'h0000;
  logic [W-1:0]  gp_o;
  logic [W-1:0]  gp_oe_o;
  logic          irq_o;

  always #5 clk_i = ~clk_i;

  gpio_bank #(.GpioWidth(W), .DbncCntWidth(CW), .SyncStages(S)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .reg_req_i(reg_req_i), .reg_we_i(reg_we_i),
    .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o),
    .reg_rvalid_o(reg_rvalid_o), .gp_i(gp_i), .gp_o(gp_o), .gp_oe_o(gp_oe_o), .irq_o(irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register values, gp_i history for the synchroniser
  // delay, per-pin agreement counts and the tick position.
  logic [W-1:0]  m_out, m_oe, m_den, m_ren, m_fen, m_st, m_filt, m_prev;
  logic [CW-1:0] m_lim;
  int            m_tcnt;
  int            m_agree[W];
  logic [W-1:0]  m_hist[$];
  logic          m_irq, m_rvalid;
  logic [31:0]   m_rdata;

  function automatic void model_reset();
    m_out = 0; m_oe = 0; m_den = 0; m_ren = 0; m_fen = 0; m_st = 0;
    m_filt = 0; m_prev = 0; m_lim = 0; m_tcnt = 0;
    m_irq = 0; m_rvalid = 0; m_rdata = 0;
    for (int i = 0; i < W; i++) m_agree[i] = 0;
    m_hist = {};
    for (int i = 0; i < S; i++) m_hist.push_back(16'h0000);
  endfunction

  function automatic logic [31:0] model_read(input int word);
    case (word)
      0: return 32'(m_out);
      1: return 32'(m_oe);
      2: return 32'(m_filt);
      3: return 32'(m_den);
      4: return 32'(m_lim);
      5: return 32'(m_ren);
      6: return 32'(m_fen);
      7: return 32'(m_st);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_edge(input bit req, input bit we, input logic [4:0] addr,
                                     input logic [31:0] wd, input logic [W-1:0] gp);
    int           word;
    bit           wr, tick;
    logic [W-1:0] sync, nfilt, w1c, set;
    word  = int'(addr) / 4;
    wr    = req && we;
    sync  = m_hist[0];
    tick  = (m_tcnt == int'(m_lim));
    nfilt = m_filt;
    w1c   = 16'h0000;
    m_rvalid = req;
    m_rdata  = (req && !we) ? model_read(word) : 32'h0;
    for (int i = 0; i < W; i++) begin
      if (!m_den[i]) begin
        nfilt[i] = sync[i];
        m_agree[i] = 0;
      end else if (sync[i] == m_filt[i]) begin
        m_agree[i] = 0;
      end else if (tick) begin
        m_agree[i]++;
        if (m_agree[i] == 3) begin
          nfilt[i] = ~m_filt[i];
          m_agree[i] = 0;
        end
      end
    end
    set = (m_filt & ~m_prev & m_ren) | (~m_filt & m_prev & m_fen);
    if (wr && word == 7) w1c = wd[W-1:0];
    m_irq  = (m_st != 0);
    m_st   = (m_st & ~w1c) | set;
    m_prev = m_filt;
    m_filt = nfilt;
    m_tcnt = (wr && word == 4) ? 0 : (tick ? 0 : m_tcnt + 1);
    void'(m_hist.pop_front());
    m_hist.push_back(gp);
    if (wr) begin
      case (word)
        0: m_out = wd[W-1:0];
        1: m_oe  = wd[W-1:0];
        3: m_den = wd[W-1:0];
        4: m_lim = wd[CW-1:0];
        5: m_ren = wd[W-1:0];
        6: m_fen = wd[W-1:0];
        default: ;
      endcase
    end
  endfunction

  task automatic check_outputs();
    chk("gp_o", 32'(gp_o), 32'(m_out));
    chk("gp_oe_o", 32'(gp_oe_o), 32'(m_oe));
    chk("irq_o", 32'(irq_o), 32'(m_irq));
    chk("rvalid", 32'(reg_rvalid_o), 32'(m_rvalid));
    chk("rdata", reg_rdata_o, m_rdata);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gp_o"}, 32'(gp_o), 32'h0);
    chk({tag, "_gp_oe_o"}, 32'(gp_oe_o), 32'h0);
    chk({tag, "_irq_o"}, 32'(irq_o), 32'h0);
    chk({tag, "_rvalid"}, 32'(reg_rvalid_o), 32'h0);
    chk({tag, "_rdata"}, reg_rdata_o, 32'h0);
  endtask

  // One bus cycle, entered and left at a falling edge
  task automatic step(input bit req, input bit we, input logic [4:0] addr, input logic [31:0] wd);
    reg_req_i = req; reg_we_i = we; reg_addr_i = addr; reg_wdata_i = wd;
    @(posedge clk_i);
    model_edge(req, we, addr, wd, gp_i);
    #1;
    check_outputs();
    @(negedge clk_i);
    reg_req_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'h00, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b1, 1'b0, a, 32'h0);
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_o;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_k;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset("por");
    rst_ni = 1'b1;

    // Register-level vectors with constant expectations
    tbl.push_back('{1'b1, 5'h00, 32'h0000A5A5, 32'h0,       16'hA5A5, 16'h0000});
    tbl.push_back('{1'b1, 5'h04, 32'h000000FF, 32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b0, 5'h00, 32'h0,        32'hA5A5,    16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b0, 5'h05, 32'h0,        32'h00FF,    16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b1, 5'h10, 32'hABCD1234, 32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b0, 5'h10, 32'h0,        32'h1234,    16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b1, 5'h0C, 32'hFFFFFFFF, 32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b0, 5'h0E, 32'h0,        32'hFFFF,    16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b1, 5'h0C, 32'h0,        32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b1, 5'h10, 32'h0,        32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b1, 5'h14, 32'h12345678, 32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b0, 5'h14, 32'h0,        32'h5678,    16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b1, 5'h14, 32'h0,        32'h0,       16'hA5A5, 16'h00FF});
    tbl.push_back('{1'b0, 5'h1C, 32'h0,        32'h0,       16'hA5A5, 16'h00FF});
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd);
      chk($sformatf("tbl%0d_rdata", i), reg_rdata_o, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_rvalid", i), 32'(reg_rvalid_o), 32'h1);
      chk($sformatf("tbl%0d_gp_o", i), 32'(gp_o), 32'(tbl[i].exp_o));
      chk($sformatf("tbl%0d_gp_oe", i), 32'(gp_oe_o), 32'(tbl[i].exp_oe));
    end

    // IN read of a held pattern, rvalid is a single pulse
    gp_i = 16'h1234;
    idle(4);
    rd(5'h08);
    chk("in_1234", reg_rdata_o, 32'h1234);
    idle(1);
    chk("rvalid_pulse", 32'(reg_rvalid_o), 32'h0);

    // Debounce with a tick every cycle: latency and glitch rejection
    gp_i = 16'h0000;
    idle(4);
    wr(5'h0C, 32'h1);
    gp_i = 16'h0001;
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      rd(5'h08);
      if (first_k == 0 && reg_rdata_o[0]) first_k = k;
    end
    chk("dbnc_lat_lim0", 32'(first_k), 32'(S + 4));
    gp_i = 16'h0000;
    idle(10);
    gp_i = 16'h0001;
    idle(2);
    gp_i = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      rd(5'h08);
      chk("glitch_in0", 32'(reg_rdata_o[0]), 32'h0);
    end

    // Debounce at limit 9, then the same with a limit rewrite part-way through
    gp_i = 16'h0001;
    wr(5'h10, 32'd9);
    first_k = 0;
    for (int k = 1; k <= 40; k++) begin
      rd(5'h08);
      if (first_k == 0 && reg_rdata_o[0]) first_k = k;
    end
    chk("dbnc_lat_lim9", 32'(first_k), 32'd31);
    wr(5'h0C, 32'h0);
    gp_i = 16'h0000;
    idle(4);
    wr(5'h0C, 32'h1);
    gp_i = 16'h0001;
    wr(5'h10, 32'd9);
    first_k = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) wr(5'h10, 32'd9);
      else begin
        rd(5'h08);
        if (first_k == 0 && reg_rdata_o[0]) first_k = k;
      end
    end
    chk("dbnc_lat_restart", 32'(first_k), 32'd36);

    // Rise on pin 1, fall on pin 2, then clear
    wr(5'h0C, 32'h0);
    wr(5'h10, 32'h0);
    gp_i = 16'h0000;
    wr(5'h14, 32'h2);
    wr(5'h18, 32'h4);
    idle(4);
    gp_i = 16'h0002; idle(10);
    gp_i = 16'h0000; idle(5);
    rd(5'h1C);
    chk("status_rise1", reg_rdata_o, 32'h2);
    gp_i = 16'h0004; idle(10);
    gp_i = 16'h0000; idle(5);
    rd(5'h1C);
    chk("status_fall2", reg_rdata_o, 32'h6);
    chk("irq_set", 32'(irq_o), 32'h1);
    wr(5'h1C, 32'h6);
    idle(1);
    chk("irq_clear", 32'(irq_o), 32'h0);
    rd(5'h1C);
    chk("status_clear", reg_rdata_o, 32'h0);

    // Clear of bit 1 in the very cycle a new rise on pin 1 sets it
    gp_i = 16'h0002;
    idle(S + 1);
    wr(5'h1C, 32'h2);
    rd(5'h1C);
    chk("set_beats_w1c", reg_rdata_o, 32'h2);

    // Asynchronous reset with pending status and a pin mid-debounce
    wr(5'h1C, 32'hFFFF);
    gp_i = 16'h0000; idle(6);
    gp_i = 16'h0006; idle(6);
    gp_i = 16'h0002; idle(6);
    rd(5'h1C);
    chk("status_pre_rst", reg_rdata_o, 32'h6);
    wr(5'h10, 32'd2);
    wr(5'h0C, 32'h8);
    gp_i = 16'h000A;
    idle(8);
    #2 rst_ni = 1'b0;
    #1 check_reset("mid_rst");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    gp_i = 16'hFFFF;
    idle(10);
    rd(5'h1C);
    chk("pullup_no_status", reg_rdata_o, 32'h0);
    chk("pullup_no_irq", 32'(irq_o), 32'h0);

    // Randomised traffic against the model
    begin
      logic [4:0]  a;
      logic [31:0] d;
      bit          req, we;
      for (int n = 0; n < 2000; n++) begin
        if ($urandom_range(0, 7) == 0) gp_i = gp_i ^ (16'($urandom) & 16'($urandom));
        req = ($urandom_range(0, 1) == 1);
        we  = ($urandom_range(0, 1) == 1);
        a   = 5'($urandom);
        d   = $urandom;
        if (a[4:2] == 3'd4) d = $urandom_range(0, 3);
        step(req, we, a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
